// File: rtl/serial_adder_8bit_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_8bit_pkg;

    // Default operand/result width in bits.
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Controller states: wait for start, add one bit per cycle, present result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_adder_8bit_pkg

// File: rtl/serial_adder_8bit_full_adder_1bit.sv
// Single-bit full adder built from gate primitives.
module full_adder_1bit (
    output logic sum,
    output logic carry_out,
    input  logic A,
    input  logic B,
    input  logic carry_in
);

    wire p_w;
    wire g_w;
    wire t_w;
    wire sum_w;
    wire cout_w;

    // Propagate/generate decomposition.
    xor u_xor_p (p_w, A, B);
    xor u_xor_s (sum_w, p_w, carry_in);
    and u_and_g (g_w, A, B);
    and u_and_t (t_w, p_w, carry_in);
    or  u_or_c  (cout_w, g_w, t_w);

    assign sum       = sum_w;
    assign carry_out = cout_w;

endmodule : full_adder_1bit

// File: rtl/serial_adder_8bit.sv
// Bit-serial adder: one full adder reused LSB-first over WIDTH cycles.
module serial_adder_8bit
    import serial_adder_8bit_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t state;
    state_t state_next;

    logic             load_c;
    logic             shift_c;
    logic             last_c;

    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next_c;
    logic             carry_q;

    logic             fa_sum;
    logic             fa_cout;

    // The one full adder, fed from the low end of the operand shifters.
    full_adder_1bit u_fa (
        .sum       (fa_sum),
        .carry_out (fa_cout),
        .A         (a_sh[0]),
        .B         (b_sh[0]),
        .carry_in  (carry_q)
    );

    // New sum bit enters from the MSB side so bit 0 ends up at position 0.
    assign res_next_c = {fa_sum, res_sh[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        shift_c    = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_c = 1'b1;
                if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                    last_c     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand shifters, carry flip-flop, partial result and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_q <= 1'b0;
            bit_cnt <= '0;
        end else if (load_c) begin
            a_sh    <= A;
            b_sh    <= B;
            res_sh  <= '0;
            carry_q <= carry_in;
            bit_cnt <= '0;
        end else if (shift_c) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res_sh  <= res_next_c;
            carry_q <= fa_cout;
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Result registers update only on the edge that finishes the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (last_c) begin
            sum       <= res_next_c;
            carry_out <= fa_cout;
            // carry_q is the carry into the MSB at this point.
            overflow  <= carry_q ^ fa_cout;
        end
    end

    // Status outputs registered from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == SHIFT);
            done <= (state_next == DONE);
        end
    end

endmodule : serial_adder_8bit

// File: tb/tb_serial_adder_8bit.sv
// Scoreboard bench for the bit-serial adder.
module tb_serial_adder_8bit;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       carry_in;
    logic [7:0] sum;
    logic       carry_out;
    logic       overflow;
    logic       busy;
    logic       done;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   done_count;
    int   last_done_cyc;
    int   prev_done_cyc;

    serial_adder_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count.
    always @(posedge clk) cyc <= cyc + 1;

    // Done pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (done) begin
            done_count    = done_count + 1;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
        end
    end

    // Reference arithmetic: signed overflow = carry into MSB ^ carry out.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [8:0] full;
        logic [7:0] low;
        exp_t       r;
        full   = {1'b0, a} + {1'b0, b} + 9'(cin);
        low    = {1'b0, a[6:0]} + {1'b0, b[6:0]} + 8'(cin);
        r.sum  = full[7:0];
        r.cout = full[8];
        r.ovf  = low[7] ^ full[8];
        return r;
    endfunction

    // Drive one start pulse; returns at the falling edge after the accepting edge.
    task automatic drive_start(input logic [7:0] a, input logic [7:0] b, input logic cin, input bit push);
        @(negedge clk);
        A        = a;
        B        = b;
        carry_in = cin;
        start    = 1'b1;
        if (push) sb_q.push_back(model(a, b, cin));
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        A        = ~a;
        B        = ~b;
        carry_in = ~cin;
    endtask

    // Count rising edges until done is seen (bounded).
    task automatic wait_done(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            lat = lat + 1;
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({sum, carry_out, overflow, busy, done} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got sum=%h co=%b ov=%b busy=%b done=%b, want all 0",
                     sum, carry_out, overflow, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int   lat;
        bit   seen;
        exp_t e;
        drive_start(8'h3C, 8'h05, 1'b0, 1'b1);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy: got %b, want 1", busy);
        end
        wait_done(lat, seen);
        // lat counted from the edge after acceptance, so done after edge N+8 gives 8.
        n_cmp++;
        if (!seen || lat != 8) begin
            n_err++;
            $display("FAIL basic_latency: got seen=%b lat=%0d, want lat=8", seen, lat);
        end
        e = sb_q.pop_front();
        n_cmp++;
        if ({sum, carry_out, overflow} !== {e.sum, e.cout, e.ovf} || sum !== 8'h41) begin
            n_err++;
            $display("FAIL basic_result: got %h/%b/%b, want 41/0/0", sum, carry_out, overflow);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy_done: got %b, want 0", busy);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_width: got %b, want 0", done);
        end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (sum !== 8'h41 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_hold: got sum=%h busy=%b, want 41/0", sum, busy);
        end
    endtask

    task automatic test_arith();
        logic [7:0] ta[4] = '{8'hFF, 8'h7F, 8'hFF, 8'h80};
        logic [7:0] tb[4] = '{8'h01, 8'h01, 8'hFF, 8'h80};
        logic       tc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_t       fixed[4];
        int         lat;
        bit         seen;
        exp_t       e;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        fixed[0] = '{sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        fixed[1] = '{sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        fixed[2] = '{sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
        fixed[3] = '{sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                ra = ta[i];
                rb = tb[i];
                rc = tc[i];
            end else begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
            end
            drive_start(ra, rb, rc, 1'b1);
            wait_done(lat, seen);
            e = sb_q.pop_front();
            if (i < 4) e = fixed[i];
            n_cmp++;
            if (!seen || {sum, carry_out, overflow} !== {e.sum, e.cout, e.ovf}) begin
                n_err++;
                $display("FAIL arith_%0d: %h+%h+%b got %h/%b/%b seen=%b, want %h/%b/%b",
                         i, ra, rb, rc, sum, carry_out, overflow, seen, e.sum, e.cout, e.ovf);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_start_ignored();
        int   lat;
        bit   seen;
        int   dc;
        exp_t e;
        dc = done_count;
        drive_start(8'h10, 8'h20, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        A     = 8'hFF;
        B     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, seen);
        e = sb_q.pop_front();
        n_cmp++;
        if (!seen || sum !== e.sum || sum !== 8'h30) begin
            n_err++;
            $display("FAIL ignore_result: got %h seen=%b, want 30", sum, seen);
        end
        repeat (14) @(posedge clk);
        #1;
        n_cmp++;
        if (done_count != dc + 1) begin
            n_err++;
            $display("FAIL ignore_pulses: got %0d done pulses, want 1", done_count - dc);
        end
    endtask

    task automatic test_reset_abort();
        int   lat;
        bit   seen;
        int   dc;
        exp_t e;
        drive_start(8'h3C, 8'h05, 1'b0, 1'b1);
        wait_done(lat, seen);
        e = sb_q.pop_front();
        n_cmp++;
        if (!seen || sum !== e.sum) begin
            n_err++;
            $display("FAIL abort_prior: got %h, want %h", sum, e.sum);
        end
        @(posedge clk);
        drive_start(8'h10, 8'h20, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        dc  = done_count;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sum !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || carry_out !== 1'b0) begin
            n_err++;
            $display("FAIL abort_clear: got sum=%h busy=%b done=%b co=%b, want 00/0/0/0",
                     sum, busy, done, carry_out);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_cmp++;
        if (done_count != dc || sum !== 8'h00) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d pulses sum=%h, want 0 pulses sum=00",
                     done_count - dc, sum);
        end
        drive_start(8'h01, 8'h01, 1'b0, 1'b1);
        wait_done(lat, seen);
        e = sb_q.pop_front();
        n_cmp++;
        if (!seen || lat != 8 || sum !== e.sum || sum !== 8'h02) begin
            n_err++;
            $display("FAIL abort_restart: got %h lat=%0d seen=%b, want 02 lat=8", sum, lat, seen);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        bit   seen;
        exp_t e;
        @(posedge clk);
        drive_start(8'hA5, 8'h3C, 1'b1, 1'b1);
        wait_done(lat, seen);
        e = sb_q.pop_front();
        n_cmp++;
        if (!seen || {sum, carry_out, overflow} !== {e.sum, e.cout, e.ovf}) begin
            n_err++;
            $display("FAIL b2b_first: got %h/%b/%b, want %h/%b/%b",
                     sum, carry_out, overflow, e.sum, e.cout, e.ovf);
        end
        // One edge later the controller is back in IDLE.
        @(posedge clk);
        drive_start(8'h7E, 8'h13, 1'b0, 1'b1);
        wait_done(lat, seen);
        e = sb_q.pop_front();
        n_cmp++;
        if (!seen || {sum, carry_out, overflow} !== {e.sum, e.cout, e.ovf}) begin
            n_err++;
            $display("FAIL b2b_second: got %h/%b/%b, want %h/%b/%b",
                     sum, carry_out, overflow, e.sum, e.cout, e.ovf);
        end
        @(negedge clk);
        n_cmp++;
        if (last_done_cyc - prev_done_cyc != 10) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles, want 10", last_done_cyc - prev_done_cyc);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        cyc           = 0;
        done_count    = 0;
        last_done_cyc = 0;
        prev_done_cyc = 0;
        start         = 1'b0;
        A             = '0;
        B             = '0;
        carry_in      = 1'b0;
        test_reset();
        test_basic();
        test_arith();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_adder_8bit

// File: doc/serial_adder_8bit.md
SERIAL_ADDER_8BIT -- requirements
Module: serial_adder_8bit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand and result width in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-003 The ports SHALL be as follows; clock and reset are listed first.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- A  input  WIDTH  augend, captured on the accepting edge.
- B  input  WIDTH  addend, captured on the accepting edge.
- carry_in  input  1  initial carry, captured on the accepting edge.
- sum  output  WIDTH  registered result.
- carry_out  output  1  registered final carry.
- overflow  output  1  registered signed overflow.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking a valid result.

Function
REQ-004 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-005 In IDLE, start=1 SHALL capture A, B and carry_in into internal shift and carry registers, clear the bit counter, and move the FSM to SHIFT.
REQ-006 Each SHIFT cycle SHALL add one bit pair, LSB first, through one full adder together with the carry flip-flop.
- The sum bit SHALL shift into the result register from the MSB side.
- The carry flip-flop SHALL update with the full adder's carry output.
REQ-007 SHIFT SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1, the FSM SHALL move to DONE.
REQ-008 On entry to DONE, the block SHALL update sum, carry_out and overflow.
- overflow SHALL equal (carry into MSB) XOR (carry out of MSB).
- done SHALL be high for exactly one cycle.
REQ-009 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-010 Latency: if start is accepted at edge N, done SHALL be high during the cycle that follows edge N+WIDTH.
REQ-011 busy SHALL be high in SHIFT and low in IDLE and DONE.
REQ-012 start SHALL be ignored in SHIFT and in DONE; in-flight operands SHALL be unaffected by input changes.
REQ-013 sum, carry_out and overflow SHALL hold their last result until the next DONE entry or reset.
REQ-014 Back-to-back operation SHALL be possible.
- start asserted in the cycle after done (IDLE) SHALL be accepted.
- Minimum spacing between accepted starts SHALL be WIDTH+2 cycles.
REQ-015 Arithmetic SHALL be modulo 2^WIDTH.
- carry_out SHALL be bit WIDTH of A+B+carry_in.
- FF+01 SHALL give sum 00 with carry_out 1.

Reset
REQ-016 While rst=1, the FSM SHALL be in IDLE.
- sum, carry_out, overflow, busy and done SHALL all be 0.
- Internal registers SHALL be 0.
REQ-017 Reset asserted during SHIFT or DONE SHALL abort the operation immediately.
- No done pulse SHALL follow.
- The previously held result SHALL be cleared to 0.
REQ-018 After reset deasserts, the first rising edge with start=1 SHALL be accepted as normal.

Structure
REQ-019 The shared package SHALL hold the FSM state enum and the default WIDTH constant.
REQ-020 The single per-bit full adder SHALL be the sub-module full_adder_1bit.
- Ports: sum, carry_out, A, B, carry_in.
- It SHALL be built from gate primitives, consistent with the existing 1-bit subtractor.
REQ-021 All state SHALL be held in flip-flops on clk with asynchronous clear by rst; there SHALL be no latches.

Verification
REQ-022 A=3C, B=05, carry_in=0, one start pulse -> done exactly 8 cycles after the accepting edge; sum=41, carry_out=0, overflow=0.
REQ-023 A=FF, B=01, carry_in=0 -> sum=00, carry_out=1, overflow=0. A=7F, B=01 -> sum=80, carry_out=0, overflow=1.
REQ-024 A=FF, B=FF, carry_in=1 -> sum=FF, carry_out=1, overflow=0. A=80, B=80, carry_in=0 -> sum=00, carry_out=1, overflow=1.
REQ-025 Start A=10, B=20, then at SHIFT cycle 3 pulse start with A=FF, B=FF -> result sum=30, with a single done pulse only.
REQ-026 Assert rst at SHIFT cycle 4 after a prior result of 41 -> sum=00, busy=0, no done; a following start with A=01, B=01 -> sum=02.
REQ-027 Issue two operations back-to-back, the second start one cycle after done -> both results correct and done pulses spaced 10 cycles apart.
